// File: rtl/div_share_ctrl.sv
// Two-requester front end for a shared fixed-point divider: round-robin grant,
// load/start sequencing, completion or timeout, and a single response channel.
module div_share_ctrl #(
  parameter int unsigned W       = 10,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic         rsp_ov,
  output logic         rsp_err,
  output logic         div_ld_a,
  output logic         div_ld_b,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_q,
  input  logic         div_ov,
  input  logic         div_done,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, RESP} state_t;

  state_t         state;
  state_t         state_n;
  logic           last_grant;
  logic           grant_c;
  logic           hs_c;
  logic           timeout_c;
  logic           drive_n;
  logic [W-1:0]   hs_a;
  logic [W-1:0]   hs_b;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [CNT_W-1:0] cnt;

  // Round-robin: a lone requester wins, otherwise the one not served last.
  always_comb begin
    grant_c = ~last_grant;
    if (req0_valid && !req1_valid) begin
      grant_c = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant_c = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant_c;
  assign req1_ready = (state == IDLE) && req1_valid && grant_c;
  assign hs_c       = req0_ready || req1_ready;
  assign hs_a       = grant_c ? req1_a : req0_a;
  assign hs_b       = grant_c ? req1_b : req0_b;
  assign timeout_c  = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (hs_c) begin
          state_n = (hs_b == '0) ? RESP : LOAD;
        end
      end
      LOAD:  state_n = START;
      START: state_n = BUSY;
      BUSY: begin
        if (div_done || timeout_c) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign drive_n = (state_n == LOAD) || (state_n == START) || (state_n == BUSY);

  // Operand capture, timeout counter, response registers and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      a_r        <= '0;
      b_r        <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q      <= '0;
      rsp_ov     <= 1'b0;
      rsp_err    <= 1'b0;
      div_ld_a   <= 1'b0;
      div_ld_b   <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      busy       <= 1'b0;
    end else begin
      if (hs_c) begin
        a_r        <= hs_a;
        b_r        <= hs_b;
        last_grant <= grant_c;
        rsp_id     <= grant_c;
        if (hs_b == '0) begin
          rsp_q   <= '1;
          rsp_ov  <= 1'b1;
          rsp_err <= 1'b0;
        end
      end

      if (state == START) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Completion takes priority over a coincident timeout.
      if (state == BUSY) begin
        if (div_done) begin
          rsp_q   <= div_q;
          rsp_ov  <= div_ov;
          rsp_err <= 1'b0;
        end else if (timeout_c) begin
          rsp_q   <= '0;
          rsp_ov  <= 1'b0;
          rsp_err <= 1'b1;
        end
      end

      rsp_valid <= (state_n == RESP);
      busy      <= (state_n != IDLE);
      div_ld_a  <= (state_n == LOAD);
      div_ld_b  <= (state_n == LOAD);
      div_start <= (state_n == START);
      div_a     <= drive_n ? ((state == IDLE) ? hs_a : a_r) : '0;
      div_b     <= drive_n ? ((state == IDLE) ? hs_b : b_r) : '0;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural divider whose latency
// and completion can be steered per job.
module tb_div_share_ctrl;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ov, rsp_err;
  logic [W-1:0] rsp_q;
  logic         div_ld_a, div_ld_b, div_start, div_ov, div_done, busy;
  logic [W-1:0] div_a, div_b, div_q;

  div_share_ctrl #(.W(W), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_ov(rsp_ov), .rsp_err(rsp_err),
    .div_ld_a(div_ld_a), .div_ld_b(div_ld_b), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_ov(div_ov),
    .div_done(div_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Divider model: done arrives lat cycles after the start pulse, q = a/b.
  int           lat  = 12;
  bit           hang = 1'b0;
  logic         stray = 1'b0;
  logic [W-1:0] ma = '0, mb = 10'd1, mq = '0;
  logic         mov = 1'b0, mdone = 1'b0;
  int           mcnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else begin
      if (div_ld_a) ma <= div_a;
      if (div_ld_b) mb <= div_b;
      mdone <= 1'b0;
      if (div_start) mcnt <= lat - 1;
      else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !hang) begin
          mdone <= 1'b1;
          mq    <= ma / mb;
          mov   <= (mb == 10'd1);
        end
      end
    end
  end

  assign div_done = mdone | stray;
  assign div_q    = stray ? 10'h155 : mq;
  assign div_ov   = stray ? 1'b1 : mov;

  typedef struct {
    bit           id;
    bit [W-1:0]   q;
    bit           ov;
    bit           err;
    int           rise;
  } exp_t;

  exp_t sb[$];
  int   grants[$];
  int   ld_cnt = 0, st_cnt = 0, ld_cyc = -1, st_cyc = -1, overlap = 0, rise_cyc = -1;
  bit   prev_rv = 1'b0;
  exp_t mon_e;

  // Monitor: strobe bookkeeping, grant log, and response scoreboard.
  always @(negedge clk) begin
    if (div_ld_a || div_ld_b) begin
      ld_cnt++;
      ld_cyc = cyc;
      if (div_ld_a != div_ld_b) overlap++;
    end
    if (div_start) begin
      st_cnt++;
      st_cyc = cyc;
      if (div_ld_a || div_ld_b) overlap++;
    end
    if (req0_valid && req0_ready) grants.push_back(0);
    if (req1_valid && req1_ready) grants.push_back(1);
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected_sb_size", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_q", rsp_q, mon_e.q);
        check("rsp_ov", rsp_ov, mon_e.ov);
        check("rsp_err", rsp_err, mon_e.err);
        check("rsp_valid_cycle", rise_cyc, mon_e.rise);
      end
    end
  end

  // Present one job on requester id, wait for its handshake, queue the expectation.
  task automatic do_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit last, output int n);
    exp_t e;
    bit   seen = 1'b0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    n = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (id ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) seen = 1'b1;
    end
    if (seen) begin
      n    = cyc;
      e.id = id;
      if (b == '0) begin
        e.q = 10'h3FF; e.ov = 1'b1; e.err = 1'b0; e.rise = n + 1;
      end else if (hang) begin
        e.q = '0; e.ov = 1'b0; e.err = 1'b1; e.rise = n + 67;
      end else begin
        e.q = a / b; e.ov = (b == 10'd1); e.err = 1'b0; e.rise = n + 3 + lat;
      end
      sb.push_back(e);
    end else begin
      check("req_handshake", seen, 1);
    end
    @(posedge clk); #1;
    if (last) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    check("drain", done, 1);
  endtask

  logic [W-1:0] c0a[3] = '{10'd100, 10'd1000, 10'd513};
  logic [W-1:0] c0b[3] = '{10'd3,   10'd10,   10'd1};
  logic [W-1:0] c1a[3] = '{10'd999, 10'd64,   10'd5};
  logic [W-1:0] c1b[3] = '{10'd7,   10'd8,    10'd9};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, n1, l0, s0;
    bit rv_seen;
    logic [15:0] snap;
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_strobes", {div_ld_a, div_ld_b, div_start}, 0);
    check("reset_div_a", div_a, 0);
    check("reset_rsp_q", rsp_q, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single job 594/100.
    do_req(1'b0, 10'b1001010010, 10'b0001100100, 1'b1, n);
    wait_drain();
    check("single_ld_cycle", ld_cyc, n + 1);
    check("single_start_cycle", st_cyc, n + 2);

    // Contention from reset: both requesters hold three jobs each.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    grants.delete();
    fork
      begin for (int k = 0; k < 3; k++) do_req(1'b0, c0a[k], c0b[k], k == 2, n0); end
      begin for (int k = 0; k < 3; k++) do_req(1'b1, c1a[k], c1b[k], k == 2, n1); end
    join
    wait_drain();
    check("grant_count", grants.size(), 6);
    for (int k = 0; k < grants.size() && k < 6; k++) check("grant_order", grants[k], k % 2);

    // Divide by zero leaves the divider untouched.
    l0 = ld_cnt; s0 = st_cnt;
    do_req(1'b1, 10'd7, 10'd0, 1'b1, n);
    wait_drain();
    check("div0_ld_count", ld_cnt, l0);
    check("div0_start_count", st_cnt, s0);

    // Timeout, recovery, then done coinciding with the last timeout cycle.
    hang = 1'b1;
    do_req(1'b0, 10'd50, 10'd5, 1'b1, n);
    wait_drain();
    hang = 1'b0;
    do_req(1'b1, 10'd99, 10'd9, 1'b1, n);
    wait_drain();
    lat = 64;
    do_req(1'b0, 10'd640, 10'd20, 1'b1, n);
    wait_drain();
    lat = 12;

    // Response backpressure with a pending request and stray done pulses.
    rsp_ready = 1'b0;
    do_req(1'b0, 10'd300, 10'd7, 1'b1, n);
    rv_seen = 1'b0;
    for (int i = 0; i < 100 && !rv_seen; i++) begin
      @(negedge clk);
      rv_seen = rsp_valid;
    end
    check("bp_rsp_valid", rv_seen, 1);
    snap = {1'b1, rsp_id, rsp_ov, rsp_err, 2'b00, rsp_q};
    fork do_req(1'b1, 10'd77, 10'd11, 1'b1, n1); join_none
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1 stray = (k % 4 == 1);
      @(negedge clk);
      check("bp_stable", {rsp_valid, rsp_id, rsp_ov, rsp_err, req0_ready, req1_ready, rsp_q}, snap);
    end
    @(posedge clk); #1 stray = 1'b0; rsp_ready = 1'b1;
    wait fork;
    wait_drain();

    // Reset in BUSY aborts the job and restores requester 0 priority.
    do_req(1'b0, 10'd200, 10'd4, 1'b1, n);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_strobes", {div_ld_a, div_ld_b, div_start, rsp_valid}, 0);
    check("rst_div_a", div_a, 0);
    sb.delete();
    rv_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rv_seen = rv_seen | rsp_valid;
    end
    check("rst_no_rsp", rv_seen, 0);
    grants.delete();
    fork
      do_req(1'b1, 10'd90, 10'd9, 1'b1, n1);
      do_req(1'b0, 10'd81, 10'd9, 1'b1, n0);
    join
    wait_drain();
    check("rst_grant_count", grants.size(), 2);
    if (grants.size() > 0) check("rst_first_grant", grants[0], 0);

    check("strobe_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Sequencer and arbiter that lets two requesters share one 10-bit fixed-point divider (start / ld_a / ld_b / A / B -> Q / ov interface).
- Accepts operand pairs through valid/ready handshakes, picks a requester by round-robin, drives the divider's load and start strobes, then waits for completion or timeout.
- Returns the quotient, overflow flag and requester id on a single response channel with valid/ready.

Parameters:
- W, 10, operand and quotient width.
- TIMEOUT, 64, maximum BUSY cycles to wait for div_done before aborting; must be >= 2.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req0_a  input  W  requester 0 dividend.
- req0_b  input  W  requester 0 divisor.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester the response belongs to.
- rsp_q  output  W  quotient.
- rsp_ov  output  1  divider overflow, or divide-by-zero.
- rsp_err  output  1  timeout abort.
- div_ld_a  output  1  load strobe for divider A.
- div_ld_b  output  1  load strobe for divider B.
- div_start  output  1  divider start pulse.
- div_a  output  W  dividend to divider.
- div_b  output  W  divisor to divider.
- div_q  input  W  divider quotient.
- div_ov  input  1  divider overflow.
- div_done  input  1  one-cycle pulse; div_q and div_ov are valid in that cycle.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, last_grant=1 (requester 0 wins first), all outputs 0, operand registers 0, timeout counter 0.
- A reset asserted in any state aborts the operation. Outputs are 0 the cycle after rst is sampled, and any pending response is discarded.
- FSM states: IDLE, LOAD, START, BUSY, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational, high only in IDLE for the granted N.
  - On handshake: latch a, b and id; update last_grant.
  - If the latched b==0, go to RESP with rsp_q = all ones, rsp_ov=1, rsp_err=0. The divider is not touched.
  - Otherwise go to LOAD.
- LOAD (1 cycle): div_ld_a=div_ld_b=1, div_a/div_b = latched operands. Next state START.
- START (1 cycle): div_start=1; div_a/div_b held. Counter cleared. Next state BUSY.
- BUSY:
  - div_a/div_b held; the counter increments each cycle.
  - On div_done: capture div_q and div_ov into the rsp registers, rsp_err=0, go to RESP.
  - If div_done has not arrived when the counter reaches TIMEOUT-1: rsp_q=0, rsp_ov=0, rsp_err=1, go to RESP.
  - If div_done arrives in the same cycle as the timeout, div_done wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q, rsp_ov and rsp_err are stable until the handshake.
  - On rsp_ready: next state IDLE. rsp_valid falls the next cycle.
  - A new request is accepted no earlier than the cycle after the response handshake.
- div_done outside BUSY is ignored.
- div_ld_a, div_ld_b and div_start are each high for exactly one cycle per job and are never high together.
- Latency:
  - Request handshake in cycle N: LOAD in N+1, START in N+2, BUSY from N+3.
  - div_done in cycle D gives rsp_valid in D+1.
  - Divide-by-zero gives rsp_valid in N+1.
- Requests not granted stay pending; their valid may remain high without side effect.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- Single job, divider model with done 12 cycles after start and q = integer A/B:
  - req0 a=10'b1001010010 (594), b=10'b0001100100 (100).
  - Required: ld strobes at N+1, start at N+2, rsp_valid at N+15 with id=0, q=5, ov=0, err=0.
- Contention:
  - req0 and req1 both valid from reset, each with 3 jobs queued.
  - Required: grant order 0,1,0,1,0,1; every rsp_id matches its job.
- Divide-by-zero:
  - req1 a=7, b=0.
  - Required: no div_ld/div_start strobe; rsp_valid next cycle with q=10'h3FF, ov=1, id=1.
- Timeout:
  - The model never pulses done; TIMEOUT=64.
  - Required: rsp_valid exactly 65 cycles after START with err=1, q=0; the next job then completes normally.
- Response backpressure:
  - rsp_ready held low for 20 cycles after rsp_valid.
  - Required: rsp fields stable; req_ready stays low; stray div_done pulses ignored.
- Reset mid-operation:
  - rst pulsed in BUSY.
  - Required: busy=0 and all strobes 0 next cycle; no response emitted; req0 is granted first afterward.
